hdx_bus_ctrl: RTL and testbench

//   Half-duplex bus controller that owns the oe/inp/outp side of a clocked

---
 rtl/hdx_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hdx_bus_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdx_bus_ctrl.sv
// hdx_bus_ctrl: half-duplex bus controller driving the oe/inp/outp side of a
// registered bidirectional pad bank. Turns single-word read/write requests
// into strobed pin activity and inserts idle turnaround cycles whenever the
// bus direction changes.
// Optional feature: define HDX_BUS_CTRL_STAT_EN to add the stat_turn output,
// a saturating 16-bit count of entries into the turnaround state.
module hdx_bus_ctrl #(
  parameter int SIZE   = 8,
  parameter int TA_CYC = 2,
  parameter int RD_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [SIZE-1:0] rsp_rdata,
  output logic [SIZE-1:0] pin_oe,
  output logic [SIZE-1:0] pin_out,
  input  logic [SIZE-1:0] pin_in,
  output logic            bus_stb,
  output logic            bus_wr
`ifdef HDX_BUS_CTRL_STAT_EN
  ,
  output logic [15:0]     stat_turn
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    WRITE = 3'd2,
    RSTB  = 3'd3,
    RWAIT = 3'd4
  } state_t;

  // Bus direction: IN means the pads are released (or about to be).
  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam logic [3:0] TA_LOAD = 4'(TA_CYC - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);

  state_t          r_state;
  logic            r_dir;
  logic            r_wr;
  logic [SIZE-1:0] r_wdata;
  logic [3:0]      r_cnt;
  logic [SIZE-1:0] r_pin_oe;
  logic [SIZE-1:0] r_pin_out;
  logic            r_bus_stb;
  logic            r_bus_wr;
  logic            r_rsp_valid;
  logic [SIZE-1:0] r_rsp_rdata;

  logic            w_accept;
  logic            w_need_turn;

  // A request is never taken in the response cycle, so the core sees the
  // response before the controller commits to the next transfer.
  assign req_ready   = (r_state == IDLE) & ~r_rsp_valid;
  assign w_accept    = req_valid & req_ready;
  assign w_need_turn = req_wr ? (r_dir == DIR_IN) : (r_dir == DIR_OUT);

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign pin_oe    = r_pin_oe;
  assign pin_out   = r_pin_out;
  assign bus_stb   = r_bus_stb;
  assign bus_wr    = r_bus_wr;

  // Transfer FSM; all pin and bus outputs are registered alongside the state
  // so each output value lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dir       <= DIR_IN;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_pin_oe    <= '0;
      r_pin_out   <= '0;
      r_bus_stb   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_bus_stb   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wr    <= req_wr;
            r_wdata <= req_wdata;
            if (w_need_turn) begin
              // Release the pads first; the new direction is taken later.
              r_state  <= TURN;
              r_dir    <= DIR_IN;
              r_pin_oe <= '0;
              r_cnt    <= TA_LOAD;
            end else if (req_wr) begin
              r_state   <= WRITE;
              r_dir     <= DIR_OUT;
              r_pin_oe  <= {SIZE{1'b1}};
              r_pin_out <= req_wdata;
              r_bus_stb <= 1'b1;
              r_bus_wr  <= 1'b1;
            end else begin
              r_state   <= RSTB;
              r_pin_oe  <= '0;
              r_bus_stb <= 1'b1;
            end
          end
        end
        TURN: begin
          if (r_cnt == 4'd0) begin
            if (r_wr) begin
              r_state   <= WRITE;
              r_dir     <= DIR_OUT;
              r_pin_oe  <= {SIZE{1'b1}};
              r_pin_out <= r_wdata;
              r_bus_stb <= 1'b1;
              r_bus_wr  <= 1'b1;
            end else begin
              r_state   <= RSTB;
              r_pin_oe  <= '0;
              r_bus_stb <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WRITE: begin
          // The written value stays parked on the pins until a read turns
          // the bus around.
          r_state <= IDLE;
        end
        RSTB: begin
          r_state <= RWAIT;
          r_cnt   <= RD_LOAD;
        end
        RWAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_rdata <= pin_in;
            r_rsp_valid <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_pin_oe <= '0;
        end
      endcase
    end
  end

`ifdef HDX_BUS_CTRL_STAT_EN
  logic [15:0] r_stat_turn;
  logic        w_turn_entry;

  assign w_turn_entry = w_accept & w_need_turn;
  assign stat_turn    = r_stat_turn;

  // Count turnaround entries, holding at the top value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_turn <= '0;
    end else if (w_turn_entry && (r_stat_turn != 16'hFFFF)) begin
      r_stat_turn <= r_stat_turn + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdx_bus_ctrl.sv
// tb_hdx_bus_ctrl: directed bench for hdx_bus_ctrl (SIZE=8, TA_CYC=2,
// RD_LAT=3). Cycle 0 is the cycle a request is presented and accepted;
// outputs are sampled 1 time unit after each rising edge.
module tb_hdx_bus_ctrl;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_wr = 1'b0;
  logic [SIZE-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic [SIZE-1:0] rsp_rdata;
  logic [SIZE-1:0] pin_oe;
  logic [SIZE-1:0] pin_out;
  logic [SIZE-1:0] pin_in = '0;
  logic            bus_stb;
  logic            bus_wr;
`ifdef HDX_BUS_CTRL_STAT_EN
  logic [15:0]     stat_turn;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hdx_bus_ctrl #(.SIZE(SIZE), .TA_CYC(2), .RD_LAT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .pin_oe    (pin_oe),
    .pin_out   (pin_out),
    .pin_in    (pin_in),
    .bus_stb   (bus_stb),
    .bus_wr    (bus_wr)
`ifdef HDX_BUS_CTRL_STAT_EN
    ,
    .stat_turn (stat_turn)
`endif
  );

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (pin_oe !== 8'h00) begin failures++; $display("FAIL reset_oe got=%h exp=00", pin_oe); end
    checks++; if (pin_out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", pin_out); end
    checks++; if (bus_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", bus_stb); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rspv got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Write from reset (dir IN): TURN in cycles 1-2, strobe in cycle 3.
  task automatic test_write_turn;
    req_valid = 1'b1; req_wr = 1'b1; req_wdata = 8'hA5;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wt_ready0 got=%b exp=1", req_ready); end
    for (int c = 1; c <= 4; c++) begin
      logic [SIZE-1:0] e_oe;
      logic            e_stb;
      logic            e_rdy;
      tick();
      req_valid = 1'b0;
      e_oe  = (c >= 3) ? 8'hFF : 8'h00;
      e_stb = (c == 3);
      e_rdy = (c == 4);
      checks++; if (pin_oe !== e_oe) begin failures++; $display("FAIL wt_oe c%0d got=%h exp=%h", c, pin_oe, e_oe); end
      checks++; if (bus_stb !== e_stb) begin failures++; $display("FAIL wt_stb c%0d got=%b exp=%b", c, bus_stb, e_stb); end
      checks++; if (req_ready !== e_rdy) begin failures++; $display("FAIL wt_ready c%0d got=%b exp=%b", c, req_ready, e_rdy); end
      if (c >= 3) begin
        checks++; if (pin_out !== 8'hA5) begin failures++; $display("FAIL wt_out c%0d got=%h exp=A5", c, pin_out); end
      end
      if (c == 3) begin
        checks++; if (bus_wr !== 1'b1) begin failures++; $display("FAIL wt_buswr got=%b exp=1", bus_wr); end
      end
    end
  endtask

  // Second write with dir already OUT: strobe in the cycle after accept.
  task automatic test_back_to_back;
    req_valid = 1'b1; req_wr = 1'b1; req_wdata = 8'h3C;
    tick();
    req_valid = 1'b0;
    checks++; if (bus_stb !== 1'b1) begin failures++; $display("FAIL b2b_stb got=%b exp=1", bus_stb); end
    checks++; if (bus_wr !== 1'b1) begin failures++; $display("FAIL b2b_buswr got=%b exp=1", bus_wr); end
    checks++; if (pin_out !== 8'h3C) begin failures++; $display("FAIL b2b_out got=%h exp=3C", pin_out); end
    checks++; if (pin_oe !== 8'hFF) begin failures++; $display("FAIL b2b_oe got=%h exp=FF", pin_oe); end
    tick();
    checks++; if (bus_stb !== 1'b0) begin failures++; $display("FAIL b2b_stb_off got=%b exp=0", bus_stb); end
    checks++; if (pin_oe !== 8'hFF) begin failures++; $display("FAIL b2b_park got=%h exp=FF", pin_oe); end
  endtask

  // Read after write: oe drops in cycle 1, RSTB in cycle 3, response cycle 7.
  task automatic test_read_after_write;
    pin_in = 8'h11;
    req_valid = 1'b1; req_wr = 1'b0; req_wdata = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      logic [3:0] got;
      logic [3:0] exp;
      tick();
      req_valid = 1'b0;
      if (c == 6) pin_in = 8'h5A;
      got = {(pin_oe != 8'h00), bus_stb, rsp_valid, req_ready};
      exp = {1'b0, (c == 3), (c == 7), (c == 8)};
      checks++; if (got !== exp) begin failures++; $display("FAIL raw_oe_stb_rspv_rdy c%0d got=%b exp=%b", c, got, exp); end
      if (c == 3) begin
        checks++; if (bus_wr !== 1'b0) begin failures++; $display("FAIL raw_buswr got=%b exp=0", bus_wr); end
      end
      if (c == 7) begin
        checks++; if (rsp_rdata !== 8'h5A) begin failures++; $display("FAIL raw_rdata got=%h exp=5A", rsp_rdata); end
      end
    end
  endtask

  // Read after read: strobe in cycle 1, response in cycle 5, ready low 1..5.
  task automatic test_read_after_read;
    pin_in = 8'hC3;
    req_valid = 1'b1; req_wr = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      logic [2:0] got;
      logic [2:0] exp;
      tick();
      req_valid = 1'b0;
      if (c == 5) pin_in = 8'h00;
      got = {bus_stb, rsp_valid, req_ready};
      exp = {(c == 1), (c == 5), (c == 6)};
      checks++; if (got !== exp) begin failures++; $display("FAIL rar_stb_rspv_rdy c%0d got=%b exp=%b", c, got, exp); end
      if (c >= 5) begin
        checks++; if (rsp_rdata !== 8'hC3) begin failures++; $display("FAIL rar_rdata c%0d got=%h exp=C3", c, rsp_rdata); end
      end
    end
  endtask

  // Reset in RWAIT kills the response; the next write takes TURN; a reset
  // while parked releases the pins immediately.
  task automatic test_reset_mid;
    pin_in = 8'h77;
    req_valid = 1'b1; req_wr = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL rm_rdata got=%h exp=00", rsp_rdata); end
    checks++; if ({pin_oe, bus_stb, rsp_valid} !== 10'b0) begin failures++; $display("FAIL rm_outs got=%h/%b/%b exp=00/0/0", pin_oe, bus_stb, rsp_valid); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_norsp c%0d got=%b exp=0", c, rsp_valid); end
    end
    req_valid = 1'b1; req_wr = 1'b1; req_wdata = 8'h96;
    for (int c = 1; c <= 3; c++) begin
      tick();
      req_valid = 1'b0;
      checks++; if (bus_stb !== (c == 3)) begin failures++; $display("FAIL rm_wstb c%0d got=%b exp=%b", c, bus_stb, (c == 3)); end
    end
    checks++; if (pin_out !== 8'h96) begin failures++; $display("FAIL rm_wout got=%h exp=96", pin_out); end
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (pin_oe !== 8'h00) begin failures++; $display("FAIL rm_park_oe got=%h exp=00", pin_oe); end
    checks++; if (pin_out !== 8'h00) begin failures++; $display("FAIL rm_park_out got=%h exp=00", pin_out); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef HDX_BUS_CTRL_STAT_EN
  task automatic test_stat;
    logic [4:0] seq;
    seq = 5'b10011; // issued LSB first: W, W, R, R, W
    checks++; if (stat_turn !== 16'd0) begin failures++; $display("FAIL stat_init got=%0d exp=0", stat_turn); end
    for (int i = 0; i < 5; i++) begin
      int waited;
      waited = 0;
      while (req_ready !== 1'b1 && waited < 40) begin
        tick();
        waited++;
      end
      if (waited >= 40) begin
        failures++; checks++;
        $display("FAIL stat_ready_wait req=%0d got=0 exp=1", i);
      end
      req_valid = 1'b1; req_wr = seq[i]; req_wdata = 8'(i);
      tick();
      req_valid = 1'b0;
    end
    for (int c = 0; c < 12; c++) tick();
    checks++; if (stat_turn !== 16'd3) begin failures++; $display("FAIL stat_turn got=%0d exp=3", stat_turn); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_turn();
    test_back_to_back();
    test_read_after_write();
    test_read_after_read();
    test_reset_mid();
`ifdef HDX_BUS_CTRL_STAT_EN
    test_stat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
